// File: rtl/decode_stage.sv
// decode_stage: splits a 32-bit instruction into fields, builds the immediate,
// hazard-control word, memory access size and illegal flag, and holds the
// result in a single output register.
//
// Handshake: a transfer happens on a side when valid && ready are both high at
// a rising clock edge. The producer keeps valid and payload stable until the
// transfer; ready may change freely. in_ready = (!out_valid || out_ready) &&
// !flush, so a held payload drains and a new one is captured in the same cycle.

package decode_stage_pkg;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instruction_t;

    // Bit 15 down to bit 0: flags first, then the two register indices.
    typedef struct packed {
        logic       is_mul;
        logic       is_instr_wb_alu;
        logic       is_instr_mem;
        logic       is_branch;
        logic       rs1_needed;
        logic       rs2_needed;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } hazard_ctrl_t;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'b00,
        SIZE_HALF  = 2'b01,
        SIZE_WORD  = 2'b10,
        SIZE_DWORD = 2'b11
    } access_size_t;
endpackage

module decode_stage #(
    parameter int INSTR_WIDTH = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    input  logic [ADDR_WIDTH-1:0]  in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [DATA_WIDTH-1:0]  out_imm,
    output logic [15:0]            out_hazard,
    output logic [1:0]             out_access_size,
    output logic                   out_mem_unsigned,
    output logic                   out_illegal,
    output logic [31:0]            out_decode_count
);
    import decode_stage_pkg::*;

    instruction_t ins;
    logic op_load, op_imm, op_auipc, op_store, op_r, op_branch, op_jal;
    logic known, illegal, accept, drain;

    instruction_t d_instr;
    logic [31:0]  d_imm32;
    hazard_ctrl_t d_haz;
    access_size_t d_size;
    logic         d_uns;

    assign ins       = instruction_t'(in_instr[31:0]);
    assign op_load   = (ins.opcode == OP_LOAD);
    assign op_imm    = (ins.opcode == OP_IMM);
    assign op_auipc  = (ins.opcode == OP_AUIPC);
    assign op_store  = (ins.opcode == OP_STORE);
    assign op_r      = (ins.opcode == OP_R);
    assign op_branch = (ins.opcode == OP_BRANCH);
    assign op_jal    = (ins.opcode == OP_JAL);
    assign known     = op_load | op_imm | op_auipc | op_store | op_r | op_branch | op_jal;
    assign illegal   = !known
                     || ((op_load || op_store) && (ins.funct3[1:0] == 2'b11))
                     || (op_store && ins.funct3[2]);

    assign in_ready = (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready && !flush;

    // Field decode; an illegal instruction keeps only its raw bits and the flag.
    always_comb begin
        d_instr = ins;
        d_imm32 = '0;
        d_haz   = '0;
        d_size  = SIZE_BYTE;
        d_uns   = 1'b0;
        if (op_store || op_branch) d_instr.rd = '0;
        if (!illegal) begin
            if (op_load || op_imm)
                d_imm32 = {{20{ins[31]}}, ins[31:20]};
            else if (op_store)
                d_imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            else if (op_branch)
                d_imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            else if (op_jal)
                d_imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            else if (op_auipc)
                d_imm32 = {ins[31:12], 12'b0};

            d_haz.is_mul          = op_r && (ins.funct7 == 7'b0000001);
            d_haz.is_instr_wb_alu = op_r | op_imm | op_auipc | op_jal;
            d_haz.is_instr_mem    = op_load;
            d_haz.is_branch       = op_branch | op_jal;
            d_haz.rs1_needed      = op_r | op_load | op_store | op_branch | op_imm;
            d_haz.rs2_needed      = op_r | op_store | op_branch;
            d_haz.rs1             = d_haz.rs1_needed ? ins.rs1 : 5'd0;
            d_haz.rs2             = d_haz.rs2_needed ? ins.rs2 : 5'd0;

            if (op_load || op_store) d_size = access_size_t'(ins.funct3[1:0]);
            d_uns = op_load && ins.funct3[2];
        end
    end

    // Output valid flag and handshake counter; flush wins over accept and drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid        <= 1'b0;
            out_decode_count <= 32'd0;
        end else begin
            if (flush)          out_valid <= 1'b0;
            else if (accept)    out_valid <= 1'b1;
            else if (out_ready) out_valid <= 1'b0;
            if (drain) out_decode_count <= out_decode_count + 32'd1;
        end
    end

    // Payload register, loaded only on an input transfer so it holds under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_pc           <= '0;
            out_instr        <= '0;
            out_imm          <= '0;
            out_hazard       <= '0;
            out_access_size  <= '0;
            out_mem_unsigned <= 1'b0;
            out_illegal      <= 1'b0;
        end else if (accept) begin
            out_pc           <= in_pc;
            out_instr        <= INSTR_WIDTH'(d_instr);
            out_imm          <= DATA_WIDTH'($signed(d_imm32));
            out_hazard       <= d_haz;
            out_access_size  <= d_size;
            out_mem_unsigned <= d_uns;
            out_illegal      <= illegal;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a
// queue-based reference model that decodes with plain integer arithmetic.
module tb_decode_stage;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] imm;
        logic [15:0] haz;
        logic [1:0]  size;
        logic        uns;
        logic        illegal;
    } exp_t;
    localparam int EW = $bits(exp_t);

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid, out_mem_unsigned, out_illegal;
    logic [31:0] in_instr, in_pc, out_pc, out_instr, out_imm, out_decode_count;
    logic [15:0] out_hazard;
    logic [1:0]  out_access_size;

    logic [EW-1:0] exp_q[$];
    logic [31:0]   exp_count;
    int            tests = 0;
    int            fails = 0;

    wire [EW-1:0] obs = {out_pc, out_instr, out_imm, out_hazard,
                         out_access_size, out_mem_unsigned, out_illegal};

    // clock / reset block
    always #5 clk = ~clk;

    decode_stage #(.INSTR_WIDTH(32), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_imm(out_imm),
        .out_hazard(out_hazard), .out_access_size(out_access_size),
        .out_mem_unsigned(out_mem_unsigned), .out_illegal(out_illegal),
        .out_decode_count(out_decode_count)
    );

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        int si, v;
        logic [6:0] op;
        logic ld, im, au, st, rr, br, jl, bad, n1, n2;
        e  = '0;
        si = ins;
        op = ins[6:0];
        ld = (op == 7'h03); im = (op == 7'h13); au = (op == 7'h17); st = (op == 7'h23);
        rr = (op == 7'h33); br = (op == 7'h63); jl = (op == 7'h6F);
        bad = !(ld || im || au || st || rr || br || jl)
            || ((ld || st) && ins[13:12] == 2'b11) || (st && ins[14]);
        e.pc = pc;
        e.instr = ins;
        if (st || br) e.instr[11:7] = 5'd0;
        e.illegal = bad;
        if (bad) return e;
        v = 0;
        if (ld || im) v = si >>> 20;
        else if (st) v = ((si >>> 25) << 5) | int'(ins[11:7]);
        else if (br) v = ((si >>> 31) << 12) | (int'(ins[7]) << 11)
                       | (int'(ins[30:25]) << 5) | (int'(ins[11:8]) << 1);
        else if (jl) v = ((si >>> 31) << 20) | (int'(ins[19:12]) << 12)
                       | (int'(ins[20]) << 11) | (int'(ins[30:21]) << 1);
        else if (au) v = int'(ins & 32'hFFFF_F000);
        e.imm = v;
        n1 = rr || ld || st || br || im;
        n2 = rr || st || br;
        e.haz = {rr && (ins[31:25] == 7'd1), rr || im || au || jl, ld, br || jl, n1, n2,
                 n1 ? ins[19:15] : 5'd0, n2 ? ins[24:20] : 5'd0};
        e.size = (ld || st) ? ins[13:12] : 2'd0;
        e.uns = ld && ins[14];
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        logic [6:0]  op;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: op = 7'h03;
            1: op = 7'h13;
            2: op = 7'h17;
            3: op = 7'h23;
            4: op = 7'h33;
            5: op = 7'h63;
            6: op = 7'h6F;
            7: op = 7'($urandom);
            8: op = 7'h7F;
            default: begin op = 7'h33; r[31:25] = 7'd1; end
        endcase
        return {r[31:7], op};
    endfunction

    // driver: advance one clock, applying the transfer rules to the model queue
    task automatic step();
        logic acc, drn;
        exp_t e;
        acc = in_valid && (exp_q.size() == 0 || out_ready) && !flush;
        drn = (exp_q.size() != 0) && out_ready && !flush;
        e = ref_decode(in_instr, in_pc);
        @(posedge clk);
        if (flush) exp_q.delete();
        else begin
            if (drn) begin void'(exp_q.pop_front()); exp_count = exp_count + 32'd1; end
            if (acc) exp_q.push_back(e);
        end
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1; in_instr = instr; in_pc = pc;
        step();
        in_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0;
        exp_q.delete(); exp_count = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
        tests++; if (out_decode_count !== 32'd0) begin fails++; $display("FAIL reset_count: got %h exp 0", out_decode_count); end
        tests++; if (obs !== '0) begin fails++; $display("FAIL reset_payload: got %h exp 0", obs); end
        rst = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    endtask

    task automatic test_directed();
        out_ready = 1'b1;
        send(32'hFFF08293, 32'h100);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL addi_valid: got %b exp 1", out_valid); end
        tests++; if (out_pc !== 32'h100) begin fails++; $display("FAIL addi_pc: got %h exp 100", out_pc); end
        tests++; if (out_imm !== 32'hFFFFFFFF) begin fails++; $display("FAIL addi_imm: got %h exp ffffffff", out_imm); end
        tests++; if (out_instr[11:7] !== 5'd5) begin fails++; $display("FAIL addi_rd: got %0d exp 5", out_instr[11:7]); end
        tests++; if (out_hazard !== 16'h4820) begin fails++; $display("FAIL addi_hazard: got %h exp 4820", out_hazard); end
        tests++; if (obs !== exp_q[0]) begin fails++; $display("FAIL addi_model: got %h exp %h", obs, exp_q[0]); end

        send(32'h022081B3, 32'h104);
        tests++; if (out_hazard !== 16'hCC22) begin fails++; $display("FAIL mul_hazard: got %h exp cc22", out_hazard); end
        tests++; if (out_imm !== 32'd0) begin fails++; $display("FAIL mul_imm: got %h exp 0", out_imm); end

        send(32'h0020A423, 32'h108);
        tests++; if (out_imm !== 32'd8) begin fails++; $display("FAIL sw_imm: got %h exp 8", out_imm); end
        tests++; if (out_access_size !== 2'b10) begin fails++; $display("FAIL sw_size: got %b exp 10", out_access_size); end
        tests++; if (out_hazard !== 16'h0C22) begin fails++; $display("FAIL sw_hazard: got %h exp 0c22", out_hazard); end
        tests++; if (out_instr[11:7] !== 5'd0) begin fails++; $display("FAIL sw_rd: got %0d exp 0", out_instr[11:7]); end

        send(32'hFE208EE3, 32'h10C);
        tests++; if (out_imm !== 32'hFFFFFFFC) begin fails++; $display("FAIL beq_imm: got %h exp fffffffc", out_imm); end
        tests++; if (out_hazard !== 16'h1C22) begin fails++; $display("FAIL beq_hazard: got %h exp 1c22", out_hazard); end
        tests++; if (out_decode_count !== 32'd3) begin fails++; $display("FAIL directed_count: got %0d exp 3", out_decode_count); end
    endtask

    task automatic test_backpressure();
        logic [31:0] c0;
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500113; in_pc = 32'h110;
        #1;
        for (int i = 0; i < 3; i++) begin
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready: got %b exp 0", in_ready); end
            tests++; if (out_imm !== 32'hFFFFFFFC || obs !== exp_q[0]) begin fails++; $display("FAIL bp_hold: got %h exp %h", obs, exp_q[0]); end
            step();
        end
        out_ready = 1'b1;
        c0 = exp_count;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b exp 1", in_ready); end
        step();
        in_valid = 1'b0;
        #1;
        tests++; if (out_decode_count !== c0 + 32'd1) begin fails++; $display("FAIL bp_count: got %0d exp %0d", out_decode_count, c0 + 32'd1); end
        tests++; if (out_valid !== 1'b1 || out_instr !== 32'h00500113) begin fails++; $display("FAIL bp_second: got %h exp 00500113", out_instr); end
    endtask

    task automatic test_flush();
        logic [31:0] c0;
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h022081B3; in_pc = 32'h200; flush = 1'b1;
        c0 = exp_count;
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_in_ready: got %b exp 0", in_ready); end
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b exp 0", out_valid); end
        tests++; if (out_decode_count !== c0) begin fails++; $display("FAIL flush_count: got %0d exp %0d", out_decode_count, c0); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        send(32'h0000007F, 32'h300);
        tests++; if (out_illegal !== 1'b1 || out_hazard !== 16'd0 || out_imm !== 32'd0) begin fails++; $display("FAIL ill_op: got ill=%b haz=%h imm=%h exp 1/0/0", out_illegal, out_hazard, out_imm); end
        send(32'h0000B283, 32'h304);
        tests++; if (out_illegal !== 1'b1 || out_hazard !== 16'd0 || out_access_size !== 2'd0) begin fails++; $display("FAIL ill_ld: got ill=%b haz=%h size=%b exp 1/0/0", out_illegal, out_hazard, out_access_size); end
        send(32'h0020C423, 32'h308);
        tests++; if (out_illegal !== 1'b1) begin fails++; $display("FAIL ill_st: got %b exp 1", out_illegal); end
        send(32'h0000C283, 32'h30C);
        tests++; if (out_illegal !== 1'b0 || out_mem_unsigned !== 1'b1 || out_hazard !== 16'h2820) begin fails++; $display("FAIL lbu: got ill=%b uns=%b haz=%h exp 0/1/2820", out_illegal, out_mem_unsigned, out_hazard); end
        tests++; if (obs !== exp_q[0]) begin fails++; $display("FAIL lbu_model: got %h exp %h", obs, exp_q[0]); end
    endtask

    task automatic test_random();
        logic mv;
        for (int n = 0; n < 800; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            in_instr  = gen_instr();
            in_pc     = $urandom & 32'hFFFF_FFFC;
            #1;
            mv = (exp_q.size() != 0);
            tests++; if (in_ready !== ((!mv || out_ready) && !flush)) begin fails++; $display("FAIL rnd_in_ready[%0d]: got %b", n, in_ready); end
            tests++; if (out_valid !== mv) begin fails++; $display("FAIL rnd_valid[%0d]: got %b exp %b", n, out_valid, mv); end
            tests++; if (out_decode_count !== exp_count) begin fails++; $display("FAIL rnd_count[%0d]: got %0d exp %0d", n, out_decode_count, exp_count); end
            if (mv) begin
                tests++; if (obs !== exp_q[0]) begin fails++; $display("FAIL rnd_payload[%0d]: got %h exp %h", n, obs, exp_q[0]); end
            end
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        step();
        tests++; if (out_valid !== 1'b0 || out_decode_count !== exp_count) begin fails++; $display("FAIL rnd_drain: got v=%b cnt=%0d exp 0/%0d", out_valid, out_decode_count, exp_count); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        send(32'hFFF08293, 32'h400);
        send(32'h022081B3, 32'h404);
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL arst_valid: got %b exp 0", out_valid); end
        tests++; if (out_decode_count !== 32'd0) begin fails++; $display("FAIL arst_count: got %0d exp 0", out_decode_count); end
        exp_q.delete(); exp_count = '0;
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(32'h0020A423, 32'h408);
        tests++; if (out_valid !== 1'b1 || obs !== exp_q[0]) begin fails++; $display("FAIL arst_recover: got %h exp %h", obs, exp_q[0]); end
        tests++; if (out_decode_count !== 32'd0) begin fails++; $display("FAIL arst_recover_count: got %0d exp 0", out_decode_count); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_illegal();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
